// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryption core, one round per clock.
// Round keys are read live from the expanded schedule on key_e.
module aes_encrypt_iter #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             in_data,
  input  logic [0:128*(NR+1)-1]    key_e,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             out_data,
  output logic                     busy
);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_encrypt_iter: NK must be 4, 6 or 8");
  end
  if (NR != NK + 6) begin : g_bad_nr
    $error("aes_encrypt_iter: NR must equal NK+6");
  end

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  function automatic logic [7:0] sub(input logic [7:0] b);
    return SBOX[8*int'(b) +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] st_q, st_d, od_d;
  logic [0:127] rk0, rk, rnd;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic         last;

  assign rk0  = key_e[0:127];
  assign rk   = key_e[128*int'(rnd_q) +: 128];
  assign last = (rnd_q == LAST);

  // Byte i sits at column i/4, row i%4.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sub(st_q[8*i +: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1]
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2])
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2])
                ^ xt(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                ^ sr[4*c+2] ^ xt(sr[4*c+3]);
    end
    rnd = '0;
    for (int i = 0; i < 16; i++) begin
      rnd[8*i +: 8] = last ? sr[i] : mc[i];
    end
    rnd = rnd ^ rk;
  end

  assign in_ready  = rst_n & ((fsm_q == IDLE) |
                              ((fsm_q == DONE) & out_ready));
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);

  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    st_d  = st_q;
    od_d  = out_data;
    unique case (1'b1)
      (fsm_q == IDLE): begin
        if (in_valid) begin
          st_d  = in_data ^ rk0;
          rnd_d = 4'd1;
          fsm_d = ROUND;
        end
      end
      (fsm_q == ROUND): begin
        st_d = rnd;
        if (last) begin
          fsm_d = DONE;
          od_d  = rnd;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      (fsm_q == DONE): begin
        if (out_ready) begin
          if (in_valid) begin
            st_d  = in_data ^ rk0;
            rnd_d = 4'd1;
            fsm_d = ROUND;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      rnd_q    <= 4'd0;
      st_q     <= '0;
      out_data <= '0;
    end else begin
      fsm_q    <= fsm_d;
      rnd_q    <= rnd_d;
      st_q     <= st_d;
      out_data <= od_d;
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: known vectors, handshake corner cases
// and random blocks against a byte-matrix AES model.
module tb_aes_encrypt_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]         iv, ordy;
  wire  [2:0]         ir, ov, bz;
  logic [2:0][0:127]  id;
  wire  [2:0][0:127]  od;
  logic [2:0][0:1919] ke;

  int total = 0;
  int bad = 0;
  logic [7:0] sbt [256];

  aes_encrypt_iter #(.NK(4), .NR(10)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .key_e(ke[0][0:1407]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .busy(bz[0])
  );

  aes_encrypt_iter #(.NK(6), .NR(12)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .key_e(ke[1][0:1663]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .busy(bz[1])
  );

  aes_encrypt_iter #(.NK(8), .NR(14)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .key_e(ke[2][0:1919]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
    .busy(bz[2])
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  function automatic logic [0:1919] expand(input logic [0:255] key,
                                           input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [0:1919] ks;
    ks = '0;
    rc = 8'h01;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      ks[32*i +: 32] = w[i];
    end
    return ks;
  endfunction

  function automatic logic [0:127] model(input logic [0:127] pt,
                                         input logic [0:1919] ks,
                                         input int nr);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [0:127] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[8*(4*c+r) +: 8] ^ ks[8*(4*c+r) +: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbt[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (rd == nr) s[r][c] = t[r][c];
          else s[r][c] = gmul(8'h02, t[r][c])
                       ^ gmul(8'h03, t[(r+1)%4][c])
                       ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = s[r][c] ^ ks[128*rd + 8*(4*c+r) +: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(4*c+r) +: 8] = s[r][c];
    return o;
  endfunction

  task automatic run_block(input int k, input logic [0:127] pt,
                           input bit junk,
                           output logic [0:127] ct, output int lat);
    @(negedge clk);
    ordy[k] = 1'b1;
    id[k] = pt;
    iv[k] = 1'b1;
    chki("in_ready_idle", int'(ir[k]), 1);
    @(posedge clk);
    #1 iv[k] = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (junk && lat == 3) begin
        iv[k] = 1'b1;
        id[k] = ~pt;
      end
      if (junk && lat == 7) iv[k] = 1'b0;
      if (ov[k]) break;
    end
    ct = od[k];
    @(posedge clk);
    #1 chki("out_valid_clear", int'(ov[k]), 0);
  endtask

  typedef struct {
    int           k;
    logic [0:255] key;
    logic [0:127] pt;
    logic [0:127] ct;
  } vec_t;

  vec_t vt [4];
  logic [0:127] ct, p [3], e [3];
  logic [0:255] rkey;
  logic [7:0] inv;
  int lat, n, nin, nout, cyc;
  int acc_c [4];
  int hs_c [4];
  bit acc, hs;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
             ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

    vt[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vt[1] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32};
    vt[2] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                  64'h0},
              128'h00112233445566778899aabbccddeeff,
              128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vt[3] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h00112233445566778899aabbccddeeff,
              128'h8ea2b7ca516745bfeafc49904b496089};

    iv = '0;
    ordy = '0;
    id = '0;
    ke = '0;
    #2 rst_n = 1'b0;
    #10;
    for (int k = 0; k < 3; k++) begin
      chki("rst_in_ready", int'(ir[k]), 0);
      chki("rst_out_valid", int'(ov[k]), 0);
      chki("rst_busy", int'(bz[k]), 0);
      chk("rst_out_data", od[k], 128'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chki("idle_in_ready", int'(ir[0]), 1);

    // known-answer vectors, all three key sizes
    for (int i = 0; i < 4; i++) begin
      ke[vt[i].k] = expand(vt[i].key, 4 + 2*vt[i].k);
      run_block(vt[i].k, vt[i].pt, 1'b0, ct, lat);
      chk("vec_ct", ct, vt[i].ct);
      chki("vec_latency", lat, 10 + 2*vt[i].k);
    end

    // output stall: hold out_ready low for 5 clocks
    ke[0] = expand(vt[1].key, 4);
    @(negedge clk);
    ordy[0] = 1'b0;
    id[0] = vt[1].pt;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chki("hold_latency", n, 10);
    iv[0] = 1'b1;
    id[0] = vt[0].pt;
    repeat (5) begin
      @(negedge clk);
      chk("hold_data", od[0], vt[1].ct);
      chki("hold_in_ready", int'(ir[0]), 0);
      chki("hold_busy", int'(bz[0]), 1);
      chki("hold_valid", int'(ov[0]), 1);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 chki("hold_release_valid", int'(ov[0]), 0);
    chki("hold_release_busy", int'(bz[0]), 0);

    // back-to-back blocks with in_valid and out_ready held high
    ke[0] = expand(vt[0].key, 4);
    for (int i = 0; i < 3; i++) begin
      p[i] = {$urandom, $urandom, $urandom, $urandom};
      e[i] = model(p[i], ke[0], 10);
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    id[0] = p[0];
    iv[0] = 1'b1;
    nin = 0;
    nout = 0;
    cyc = 0;
    while (nout < 3 && cyc < 100) begin
      @(negedge clk);
      acc = iv[0] && ir[0];
      hs = ov[0] && ordy[0];
      if (hs) begin
        chk("b2b_ct", od[0], e[nout]);
        hs_c[nout] = cyc;
        nout++;
      end
      if (acc && nin < 4) acc_c[nin] = cyc;
      @(posedge clk);
      #1;
      if (acc) begin
        nin++;
        if (nin < 3) id[0] = p[nin];
        else iv[0] = 1'b0;
      end
      cyc++;
    end
    chki("b2b_outputs", nout, 3);
    chki("b2b_accepts", nin, 3);
    chki("b2b_gap01", acc_c[1] - acc_c[0], 11);
    chki("b2b_gap12", acc_c[2] - acc_c[1], 11);
    chki("b2b_first_out", hs_c[0] - acc_c[0], 11);
    chki("b2b_accept_on_hs", acc_c[1], hs_c[0]);

    // new data offered mid-round is ignored
    run_block(0, vt[0].pt, 1'b1, ct, lat);
    chk("midround_ct", ct, vt[0].ct);
    chki("midround_latency", lat, 10);

    // reset asserted at round 5
    @(negedge clk);
    ordy[0] = 1'b1;
    id[0] = vt[1].pt;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chki("midrst_out_valid", int'(ov[0]), 0);
    chki("midrst_in_ready", int'(ir[0]), 0);
    chki("midrst_busy", int'(bz[0]), 0);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0]) n++;
    end
    chki("midrst_no_output", n, 0);
    chki("midrst_in_ready_after", int'(ir[0]), 1);
    run_block(0, vt[0].pt, 1'b0, ct, lat);
    chk("midrst_next_ct", ct, vt[0].ct);

    // random keys and blocks for every key size
    for (int k = 0; k < 3; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
      ke[k] = expand(rkey, 4 + 2*k);
      for (int j = 0; j < 5; j++) begin
        p[0] = {$urandom, $urandom, $urandom, $urandom};
        run_block(k, p[0], 1'b0, ct, lat);
        chk("rand_ct", ct, model(p[0], ke[k], 10 + 2*k));
        chki("rand_latency", lat, 10 + 2*k);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
